// File: rtl/hpu_palette_out_if.sv
// CPU palette write port: valid/ready handshake carrying entry index and colour.
// master drives valid/index/rgb and samples ready; slave returns ready.
interface hpu_palette_out_if #(
  parameter int RGB_W = 12
);
  logic             cpu_wr_valid;
  logic             cpu_wr_ready;
  logic [4:0]       cpu_wr_index;
  logic [RGB_W-1:0] cpu_wr_rgb;

  modport master (
    output cpu_wr_valid,
    output cpu_wr_index,
    output cpu_wr_rgb,
    input  cpu_wr_ready
  );

  modport slave (
    input  cpu_wr_valid,
    input  cpu_wr_index,
    input  cpu_wr_rgb,
    output cpu_wr_ready
  );
endinterface

// File: rtl/hpu_palette_out.sv
// HPU output colour stage: 4x8 palette lookup to registered RGB, blanked outside
// the active area. Ports: clk, reset (async active-low), true_line/true_column
// raster position, hpu_pixel_in/hpu_pallet_in index, cpu (slave) palette write
// port, rgb_out/rgb_active registered colour and visibility flag.
module hpu_palette_out #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int RGB_W    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       true_line,
  input  logic [9:0]       true_column,
  input  logic [2:0]       hpu_pixel_in,
  input  logic [1:0]       hpu_pallet_in,
  hpu_palette_out_if.slave cpu,
  output logic [RGB_W-1:0] rgb_out,
  output logic             rgb_active
);

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } wr_state_t;

  wr_state_t        r_state;
  logic [4:0]       r_hold_idx;
  logic [RGB_W-1:0] r_hold_rgb;
  logic [RGB_W-1:0] r_pal [32];

  logic             w_active;
  logic             w_blank;
  logic [4:0]       w_rd_idx;
  logic             w_accept;

  assign w_active = (true_column < H_LIM)
                 && (true_line < V_LIM);
  assign w_blank  = !w_active;
  assign w_rd_idx = {hpu_pallet_in, hpu_pixel_in};

  // ready is a pure state decode, so no path from valid
  assign cpu.cpu_wr_ready = (r_state == IDLE);
  assign w_accept = cpu.cpu_wr_valid
                 && (r_state == IDLE);

  // Write FSM: latch in IDLE, commit to the palette on the first blank edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_hold_idx <= '0;
      r_hold_rgb <= '0;
      for (int i = 0; i < 32; i++) begin
        r_pal[i] <= '0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_hold_idx <= cpu.cpu_wr_index;
            r_hold_rgb <= cpu.cpu_wr_rgb;
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (w_blank) begin
            r_pal[r_hold_idx] <= r_hold_rgb;
            r_state           <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Lookup: one clock latency, forced to zero when blank
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_out    <= '0;
      rgb_active <= 1'b0;
    end else begin
      rgb_out    <= w_active ? r_pal[w_rd_idx] : '0;
      rgb_active <= w_active;
    end
  end

endmodule

// File: tb/tb_hpu_palette_out.sv
// Directed self-checking bench for hpu_palette_out: reset, blank/deferred
// commits, boundaries, back-to-back writes and a table of lookup vectors.
module tb_hpu_palette_out;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  true_line = '0;
  logic [9:0]  true_column = '0;
  logic [2:0]  hpu_pixel_in = '0;
  logic [1:0]  hpu_pallet_in = '0;
  logic [11:0] rgb_out;
  logic        rgb_active;

  int errors = 0;
  int checks = 0;

  hpu_palette_out_if #(.RGB_W(12)) bus ();

  hpu_palette_out #(
    .H_ACTIVE(640),
    .V_ACTIVE(480),
    .RGB_W(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .true_line(true_line),
    .true_column(true_column),
    .hpu_pixel_in(hpu_pixel_in),
    .hpu_pallet_in(hpu_pallet_in),
    .cpu(bus.slave),
    .rgb_out(rgb_out),
    .rgb_active(rgb_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  line;
    logic [9:0]  col;
    logic [1:0]  pal;
    logic [2:0]  pix;
    logic [11:0] exp_rgb;
    logic        exp_act;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pos(input logic [9:0] l,
                     input logic [9:0] c);
    true_line   = l;
    true_column = c;
  endtask

  task automatic sel(input logic [1:0] p,
                     input logic [2:0] x);
    hpu_pallet_in = p;
    hpu_pixel_in  = x;
  endtask

  // single write issued in blank: one clk not ready, then commit
  task automatic blank_write(input logic [4:0] idx,
                             input logic [11:0] rgb,
                             input string name);
    pos(10'd500, 10'd0);
    bus.cpu_wr_valid = 1'b1;
    bus.cpu_wr_index = idx;
    bus.cpu_wr_rgb   = rgb;
    tick();
    chk({name, "_ready_low"}, 32'(bus.cpu_wr_ready), 0);
    bus.cpu_wr_valid = 1'b0;
    tick();
    chk({name, "_ready_back"}, 32'(bus.cpu_wr_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int acc [4];

    // final lookup table, expectations from the writes below
    vecs[0]  = '{10'd11,  10'd0,    2'd1, 3'd3, 12'hF80, 1'b1};
    vecs[1]  = '{10'd0,   10'd0,    2'd0, 3'd0, 12'h0F0, 1'b1};
    vecs[2]  = '{10'd1,   10'd1,    2'd0, 3'd1, 12'h111, 1'b1};
    vecs[3]  = '{10'd2,   10'd2,    2'd0, 3'd2, 12'h222, 1'b1};
    vecs[4]  = '{10'd3,   10'd3,    2'd0, 3'd3, 12'h333, 1'b1};
    vecs[5]  = '{10'd479, 10'd639,  2'd0, 3'd4, 12'h444, 1'b1};
    vecs[6]  = '{10'd4,   10'd4,    2'd0, 3'd5, 12'h000, 1'b1};
    vecs[7]  = '{10'd5,   10'd5,    2'd0, 3'd7, 12'hABC, 1'b1};
    vecs[8]  = '{10'd6,   10'd6,    2'd1, 3'd0, 12'h123, 1'b1};
    vecs[9]  = '{10'd0,   10'd1023, 2'd1, 3'd3, 12'h000, 1'b0};
    vecs[10] = '{10'd1023,10'd0,    2'd1, 3'd3, 12'h000, 1'b0};
    vecs[11] = '{10'd480, 10'd639,  2'd0, 3'd0, 12'h000, 1'b0};

    bus.cpu_wr_valid = 1'b0;
    bus.cpu_wr_index = '0;
    bus.cpu_wr_rgb   = '0;

    // 1: reset state, then reset asserted mid-HOLD
    tick();
    tick();
    chk("rst_rgb", 32'(rgb_out), 0);
    chk("rst_act", 32'(rgb_active), 0);
    chk("rst_ready", 32'(bus.cpu_wr_ready), 1);
    reset = 1'b1;
    pos(10'd10, 10'd100);
    sel(2'd0, 3'd5);
    bus.cpu_wr_valid = 1'b1;
    bus.cpu_wr_index = 5'd5;
    bus.cpu_wr_rgb   = 12'h123;
    tick();
    chk("hold_ready", 32'(bus.cpu_wr_ready), 0);
    chk("hold_act", 32'(rgb_active), 1);
    bus.cpu_wr_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_ready", 32'(bus.cpu_wr_ready), 1);
    chk("async_act", 32'(rgb_active), 0);
    tick();
    reset = 1'b1;
    pos(10'd10, 10'd700);
    tick();
    tick();
    pos(10'd10, 10'd100);
    tick();
    chk("rst_entry5", 32'(rgb_out), 0);
    chk("rst_entry5_act", 32'(rgb_active), 1);

    // 2: write in blank, then visible read
    pos(10'd10, 10'd700);
    bus.cpu_wr_valid = 1'b1;
    bus.cpu_wr_index = 5'b01_011;
    bus.cpu_wr_rgb   = 12'hF80;
    tick();
    chk("t2_ready_low", 32'(bus.cpu_wr_ready), 0);
    bus.cpu_wr_valid = 1'b0;
    tick();
    chk("t2_ready_back", 32'(bus.cpu_wr_ready), 1);
    pos(10'd11, 10'd0);
    sel(2'd1, 3'd3);
    tick();
    chk("t2_rgb", 32'(rgb_out), 32'h0F80);
    chk("t2_act", 32'(rgb_active), 1);

    // 4: blanking output with pal[0]=FFF
    blank_write(5'd0, 12'hFFF, "t4_wr");
    pos(10'd5, 10'd0);
    sel(2'd0, 3'd0);
    tick();
    chk("t4_vis_rgb", 32'(rgb_out), 32'hFFF);
    pos(10'd5, 10'd640);
    tick();
    chk("t4_col640_rgb", 32'(rgb_out), 0);
    chk("t4_col640_act", 32'(rgb_active), 0);
    pos(10'd480, 10'd0);
    tick();
    chk("t4_line480_rgb", 32'(rgb_out), 0);
    chk("t4_line480_act", 32'(rgb_active), 0);

    // 3: deferred write, old colour through col 639
    pos(10'd20, 10'd100);
    sel(2'd0, 3'd0);
    bus.cpu_wr_valid = 1'b1;
    bus.cpu_wr_index = 5'd0;
    bus.cpu_wr_rgb   = 12'h0F0;
    tick();
    chk("t3_accept_rgb", 32'(rgb_out), 32'hFFF);
    bus.cpu_wr_valid = 1'b0;
    for (int c = 101; c < 640; c++) begin
      true_column = 10'(c);
      tick();
      chk("t3_old_rgb", 32'(rgb_out), 32'hFFF);
      chk("t3_ready_low", 32'(bus.cpu_wr_ready), 0);
    end
    true_column = 10'd640;
    tick();
    chk("t3_commit_rgb", 32'(rgb_out), 0);
    chk("t3_ready_641", 32'(bus.cpu_wr_ready), 1);
    pos(10'd21, 10'd0);
    tick();
    chk("t3_new_rgb", 32'(rgb_out), 32'h0F0);

    // 5: boundary latches at col 639
    pos(10'd30, 10'd639);
    bus.cpu_wr_valid = 1'b1;
    bus.cpu_wr_index = 5'd7;
    bus.cpu_wr_rgb   = 12'hABC;
    tick();
    chk("t5a_ready_low", 32'(bus.cpu_wr_ready), 0);
    bus.cpu_wr_valid = 1'b0;
    true_column = 10'd640;
    tick();
    chk("t5a_ready_back", 32'(bus.cpu_wr_ready), 1);
    pos(10'd479, 10'd639);
    bus.cpu_wr_valid = 1'b1;
    bus.cpu_wr_index = 5'b01_000;
    bus.cpu_wr_rgb   = 12'h123;
    tick();
    chk("t5b_ready_low", 32'(bus.cpu_wr_ready), 0);
    bus.cpu_wr_valid = 1'b0;
    true_column = 10'd640;
    tick();
    chk("t5b_ready_back", 32'(bus.cpu_wr_ready), 1);

    // 6: back-to-back with valid held high in blank
    pos(10'd500, 10'd0);
    n = 0;
    bus.cpu_wr_valid = 1'b1;
    for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
      bus.cpu_wr_index = 5'(n + 1);
      bus.cpu_wr_rgb   = 12'(12'h111 * (n + 1));
      if (bus.cpu_wr_ready === 1'b1) begin
        acc[n] = cyc;
        n++;
      end
      tick();
    end
    bus.cpu_wr_valid = 1'b0;
    tick();
    chk("t6_accepts", 32'(n), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n) chk("t6_spacing", 32'(acc[i]), 32'(2 * i));
    end

    // table of lookups
    for (int i = 0; i < 12; i++) begin
      pos(vecs[i].line, vecs[i].col);
      sel(vecs[i].pal, vecs[i].pix);
      tick();
      chk($sformatf("vec%0d_rgb", i),
          32'(rgb_out), 32'(vecs[i].exp_rgb));
      chk($sformatf("vec%0d_act", i),
          32'(rgb_active), 32'(vecs[i].exp_act));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
